ecc_corr39: RTL
===============

# ecc_corr39

SECDED decode/correct pipeline for 39-bit words produced by `EccGet32`. Each word carries 32 data bits, 6 Hamming bits and 1 overall parity bit. The block computes the syndrome and corrects single-bit errors. It flags double-bit and other uncorrectable errors, counts error events, and issues a scrub write-back request carrying the corrected codeword. It sits on the read-return path of ECC-protected arrays (L2 data, TLB, and register-file spill).

## Interface
Parameters:
- `TAG_W`, 8 — width of the opaque request tag carried alongside each word.
- `CNT_W`, 16 — width of the saturating error counters.

Ports:
- `clk` in 1 — sole clock; everything is rising-edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_vld` in 1 — input word valid.
- `in_rdy` out 1 — input accepted when `in_vld & in_rdy`.
- `in_cw` in 39 — codeword, `EccGet32` layout. Check bits sit at positions 0, 1, 3, 7, 15, 31. Bit 38 is the XOR of bits 37:0.
- `in_tag` in `TAG_W` — request tag.
- `out_vld` out 1 — decoded result valid.
- `out_rdy` in 1 — downstream accepts.
- `out_data` out 32 — corrected data, extracted as {cw[37:32], cw[30:16], cw[14:8], cw[6:4], cw[2]}.
- `out_tag` out `TAG_W` — tag of the result.
- `out_ce` out 1 — correctable error was present.
- `out_ue` out 1 — uncorrectable error; `out_data` is uncorrected raw extraction.
- `out_syn` out 7 — {overall parity p, syndrome s[5:0]}.
- `scrub_vld` out 1 — scrub request pending.
- `scrub_rdy` in 1 — scrub request consumed.
- `scrub_cw` out 39 — corrected codeword to write back.
- `scrub_tag` out `TAG_W` — tag of the scrub request.
- `scrub_ovf` out 1 — sticky; a CE scrub was dropped because the slot was busy.
- `clr` in 1 — synchronous clear of counters, `scrub_ovf` and the log.
- `ce_cnt` out `CNT_W` — saturating correctable-error count.
- `ue_cnt` out `CNT_W` — saturating uncorrectable-error count.
- `log_vld` out 1 — first-error log captured.
- `log_tag` out `TAG_W` — tag of the first logged error.
- `log_syn` out 7 — `out_syn` of the first logged error.

## Operation
- Syndrome:
  - s[k] = XOR of cw[j] for j in 0..37 where bit k of (j+1) is set.
  - p = XOR of cw[38:0].
- Classification:
  - s=0, p=0: clean.
  - s=0, p=1: CE, bit 38 flipped; data unaffected; scrub rewrites cw with bit 38 fixed.
  - s in 1..38, p=1: CE; flip cw[s-1].
  - s in 39..63, p=1: UE (position out of range).
  - s≠0, p=0: UE (double error).
- UE: no scrub request; `out_data` comes from the raw codeword.
- Pipeline, two stages:
  - S1 registers `in_cw` and `in_tag`.
  - S1→S2 computes syndrome, classification and correction. S2 holds the `out_*` registers.
  - Global stall: `adv = ~out_vld | out_rdy`; `in_rdy = adv`. Both stages load when `adv`; S2 empties when S1 is empty.
- Counters:
  - Increment on the S2 load of a CE or UE result.
  - Saturate at all-ones.
  - `clr` takes priority over a same-cycle increment; the result is 0.
- Scrub slot: single entry.
  - A CE loading into S2 while `scrub_vld=0`, or while `scrub_vld & scrub_rdy` in the same cycle, fills the slot.
  - Otherwise the scrub is dropped and `scrub_ovf` is set.
  - `scrub_vld` stays held until `scrub_rdy`.

## Timing
- Latency: 2 cycles from input handshake to `out_vld`, with no stall.
- Throughput: 1 word/cycle.
- `out_*` and `scrub_*` hold stable while valid and not ready.
- `scrub_vld` rises in the same cycle as `out_vld` for that CE word.
- Reset values: all outputs 0, including both valid flags, the counters, `scrub_ovf` and the log. `in_rdy` is 1 after reset.
- Reset mid-operation discards in-flight words and any pending scrub. No partial output appears.
- `clr` in the same cycle as an error event: clear wins; the event is not counted or logged.

## Configuration
- `ECC_ERR_LOG_EN` defined:
  - The first CE or UE entering S2 after reset or `clr` captures `log_tag` and `log_syn` and sets `log_vld`.
  - Later errors do not overwrite the log.
  - A UE overwrites a logged CE exactly once, so UE takes precedence.
- Not defined: `log_vld`, `log_tag` and `log_syn` are tied to 0 and no log flops are built.

## Test plan
- Clean word: EccGet32(32'hDEADBEEF) with `out_rdy=1` → `out_data=32'hDEADBEEF` 2 cycles later, `out_ce=0`, `out_ue=0`, `out_syn=0`, counters unchanged.
- Single flip: data 32'h12345678, flip cw[20] → `out_data=32'h12345678`, `out_ce=1`, s=21, p=1, `scrub_cw` equals the clean codeword, `ce_cnt=1`.
- Double flip: flip cw[2] and cw[9] → `out_ue=1`, p=0, no `scrub_vld`, `ue_cnt=1`. With `ECC_ERR_LOG_EN`, `log_syn` holds this syndrome.
- Back-pressure: stream 4 words with `out_rdy=0` for 5 cycles → `in_rdy=0` after 2 words are accepted; no loss or duplication after release; order preserved.
- Scrub overflow: two consecutive CE words, `scrub_rdy=0` → first scrub held, `scrub_ovf=1`, `ce_cnt=2`. A subsequent `clr` zeroes the counters, `scrub_ovf` and the log.
- Saturation/reset: `CNT_W=2`, 5 CE words → `ce_cnt=3`. Assert `rst_n=0` mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ecc_corr39.sv
// ecc_corr39: two-stage SECDED check/correct for 39-bit EccGet32 words, with saturating
// error counters and a single-entry scrub slot. Define ECC_ERR_LOG_EN to build the first-error log.
module ecc_corr39 #(
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [38:0]      in_cw,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ce,
    output logic             out_ue,
    output logic [6:0]       out_syn,
    output logic             scrub_vld,
    input  logic             scrub_rdy,
    output logic [38:0]      scrub_cw,
    output logic [TAG_W-1:0] scrub_tag,
    output logic             scrub_ovf,
    input  logic             clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt,
    output logic             log_vld,
    output logic [TAG_W-1:0] log_tag,
    output logic [6:0]       log_syn
);

    // Syndrome bit k covers every position whose 1-based index has bit k set.
    function automatic logic [5:0] calc_syn(input logic [38:0] cw);
        logic [5:0] s;
        s = 6'd0;
        for (int j = 0; j < 38; j++) begin
            s = s ^ (6'(j + 1) & {6{cw[j]}});
        end
        return s;
    endfunction

    function automatic logic [31:0] get_data(input logic [38:0] cw);
        return {cw[37:32], cw[30:16], cw[14:8], cw[6:4], cw[2]};
    endfunction

    logic             s1_vld_q;
    logic [38:0]      s1_cw_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             adv_s;
    logic             ld2_s;
    logic [5:0]       syn_s;
    logic             par_s;
    logic [38:0]      flip_s;
    logic [38:0]      fix_cw_s;
    logic             ce_s;
    logic             ue_s;
    logic             out_vld_q;
    logic [31:0]      out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_ce_q;
    logic             out_ue_q;
    logic [6:0]       out_syn_q;
    logic             scrub_vld_q;
    logic [38:0]      scrub_cw_q;
    logic [TAG_W-1:0] scrub_tag_q;
    logic             scrub_ovf_q;
    logic             scrub_fill_s;
    logic             scrub_drop_s;
    logic [CNT_W-1:0] ce_cnt_q;
    logic [CNT_W-1:0] ce_cnt_d;
    logic [CNT_W-1:0] ue_cnt_q;
    logic [CNT_W-1:0] ue_cnt_d;

    assign adv_s  = ~out_vld_q | out_rdy;
    assign ld2_s  = adv_s & s1_vld_q;
    assign in_rdy = adv_s;

    // Stage 1: capture the raw codeword and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_cw_q  <= 39'd0;
            s1_tag_q <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s1_vld_q <= in_vld;
            s1_cw_q  <= in_cw;
            s1_tag_q <= in_tag;
        end else begin
            s1_vld_q <= s1_vld_q;
        end
    end

    // Syndrome, classification and single-bit correction of the stage-1 word.
    always_comb begin
        syn_s  = calc_syn(s1_cw_q);
        par_s  = ^s1_cw_q;
        flip_s = 39'd0;
        ce_s   = 1'b0;
        ue_s   = 1'b0;
        case ({par_s, syn_s == 6'd0})
            2'b01: ce_s = 1'b0;
            2'b11: begin
                flip_s = {1'b1, 38'd0};
                ce_s   = 1'b1;
            end
            2'b10: begin
                if (syn_s <= 6'd38) begin
                    flip_s = 39'd1 << (syn_s - 6'd1);
                    ce_s   = 1'b1;
                end else begin
                    ue_s = 1'b1;
                end
            end
            2'b00:   ue_s = 1'b1;
            default: ue_s = 1'b1;
        endcase
        fix_cw_s = s1_cw_q ^ flip_s;
    end

    // Stage 2: result registers; flip_s is zero on UE so data stays raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= 32'd0;
            out_tag_q  <= {TAG_W{1'b0}};
            out_ce_q   <= 1'b0;
            out_ue_q   <= 1'b0;
            out_syn_q  <= 7'd0;
        end else if (adv_s) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_data_q <= get_data(fix_cw_s);
                out_tag_q  <= s1_tag_q;
                out_ce_q   <= ce_s;
                out_ue_q   <= ue_s;
                out_syn_q  <= {par_s, syn_s};
            end
        end else begin
            out_vld_q <= out_vld_q;
        end
    end

    assign scrub_fill_s = ld2_s & ce_s & (~scrub_vld_q | scrub_rdy);
    assign scrub_drop_s = ld2_s & ce_s & scrub_vld_q & ~scrub_rdy;

    // Single-entry scrub slot and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scrub_vld_q <= 1'b0;
            scrub_cw_q  <= 39'd0;
            scrub_tag_q <= {TAG_W{1'b0}};
            scrub_ovf_q <= 1'b0;
        end else begin
            if (scrub_fill_s) begin
                scrub_vld_q <= 1'b1;
                scrub_cw_q  <= fix_cw_s;
                scrub_tag_q <= s1_tag_q;
            end else if (scrub_rdy) begin
                scrub_vld_q <= 1'b0;
            end else begin
                scrub_vld_q <= scrub_vld_q;
            end
            if (clr) begin
                scrub_ovf_q <= 1'b0;
            end else if (scrub_drop_s) begin
                scrub_ovf_q <= 1'b1;
            end else begin
                scrub_ovf_q <= scrub_ovf_q;
            end
        end
    end

    // Saturating counters; clr beats a same-cycle increment.
    always_comb begin
        ce_cnt_d = ce_cnt_q;
        ue_cnt_d = ue_cnt_q;
        if (clr) begin
            ce_cnt_d = {CNT_W{1'b0}};
            ue_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (ld2_s && ce_s && !(&ce_cnt_q)) begin
                ce_cnt_d = ce_cnt_q + CNT_W'(1);
            end else begin
                ce_cnt_d = ce_cnt_q;
            end
            if (ld2_s && ue_s && !(&ue_cnt_q)) begin
                ue_cnt_d = ue_cnt_q + CNT_W'(1);
            end else begin
                ue_cnt_d = ue_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt_q <= {CNT_W{1'b0}};
            ue_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ce_cnt_q <= ce_cnt_d;
            ue_cnt_q <= ue_cnt_d;
        end
    end

`ifdef ECC_ERR_LOG_EN
    logic             log_vld_q;
    logic             log_ue_q;
    logic [TAG_W-1:0] log_tag_q;
    logic [6:0]       log_syn_q;
    logic             log_cap_s;

    // A UE may replace a logged CE once; otherwise the first error sticks.
    assign log_cap_s = ld2_s & (ce_s | ue_s) & (~log_vld_q | (ue_s & ~log_ue_q));

    // First-error log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_vld_q <= 1'b0;
            log_ue_q  <= 1'b0;
            log_tag_q <= {TAG_W{1'b0}};
            log_syn_q <= 7'd0;
        end else if (clr) begin
            log_vld_q <= 1'b0;
            log_ue_q  <= 1'b0;
            log_tag_q <= {TAG_W{1'b0}};
            log_syn_q <= 7'd0;
        end else if (log_cap_s) begin
            log_vld_q <= 1'b1;
            log_ue_q  <= ue_s;
            log_tag_q <= s1_tag_q;
            log_syn_q <= {par_s, syn_s};
        end else begin
            log_vld_q <= log_vld_q;
        end
    end

    assign log_vld = log_vld_q;
    assign log_tag = log_tag_q;
    assign log_syn = log_syn_q;
`else
    assign log_vld = 1'b0;
    assign log_tag = {TAG_W{1'b0}};
    assign log_syn = 7'd0;
`endif

    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_ce    = out_ce_q;
    assign out_ue    = out_ue_q;
    assign out_syn   = out_syn_q;
    assign scrub_vld = scrub_vld_q;
    assign scrub_cw  = scrub_cw_q;
    assign scrub_tag = scrub_tag_q;
    assign scrub_ovf = scrub_ovf_q;
    assign ce_cnt    = ce_cnt_q;
    assign ue_cnt    = ue_cnt_q;

endmodule
